// File: rtl/pipe_pkg.sv
// pipe_pkg: types and constants shared by the pipeline-control slice.
//   pipe_state_e : controller state (RUN, MDU_BUSY)
//   REG_ZERO     : architectural zero register index (never a real hazard)
package pipe_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } pipe_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: pipeline hazard/control signal bundle.
//   Decode side : id_rs1, id_rs2, id_uses_rs1, id_uses_rs2
//   Execute side: id_ex_mem_read, id_ex_rd, ex_branch_taken, mdu_start, mdu_done
//   Controls    : pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_bubble
//   Status      : mdu_timeout (one-cycle pulse), stall_cnt (CNT_W bits)
// master drives the pipeline status and observes controls; slave is pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             id_ex_mem_read;
  logic [4:0]       id_ex_rd;
  logic             ex_branch_taken;
  logic             mdu_start;
  logic             mdu_done;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_bubble;
  logic             mdu_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_mem_read, id_ex_rd,
           ex_branch_taken, mdu_start, mdu_done,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_bubble,
           mdu_timeout, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_mem_read, id_ex_rd,
           ex_branch_taken, mdu_start, mdu_done,
    output pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_bubble,
           mdu_timeout, stall_cnt
  );
endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use compare.
//   mem_read, ex_rd      : load in EX and its destination register
//   rs1/rs2, uses_rs1/2  : ID sources and whether they are actually read
//   load_use             : ID instruction needs a value the EX load has not produced
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] rs1,
  input  logic       uses_rs1,
  input  logic [4:0] rs2,
  input  logic       uses_rs2,
  output logic       load_use
);

  // Writes to the zero register are discarded, so they never create a dependency.
  always_comb begin
    load_use = mem_read && (ex_rd != REG_ZERO) &&
               ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with multi-cycle MDU wait and watchdog.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : pipe_ctrl_if.slave (hazard inputs, control outputs, stall_cnt)
// Parameters: MDU_MAX_CYCLES (watchdog limit), CNT_W (stall counter width).
// Build option: PIPE_CTRL_MDU_EN enables the MDU_BUSY wait, watchdog and
// ex_mem_bubble; without it mdu_start/mdu_done are ignored and the block only
// handles load-use stalls and branch flushes.
// Control outputs are combinational on the current-cycle hazard inputs and are
// forced low while rst is high.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_MAX_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam int WAIT_W = (MDU_MAX_CYCLES > 2) ? $clog2(MDU_MAX_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MDU_MAX_CYCLES - 1);

  pipe_state_e       state_r;
  pipe_state_e       state_next_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic              load_use_s;
  logic              mdu_start_s;
  logic              mdu_done_s;
  logic              mdu_entry_s;
  logic              pc_stall_s;
  logic              if_id_stall_s;
  logic              if_id_flush_s;
  logic              id_ex_flush_s;
  logic              ex_mem_bubble_s;
  logic              mdu_timeout_s;

`ifdef PIPE_CTRL_MDU_EN
  assign mdu_start_s = bus.mdu_start;
  assign mdu_done_s  = bus.mdu_done;
`else
  // With the MDU path compiled out the handshake never reaches the FSM, so it
  // can never leave RUN and the bubble/timeout outputs stay low.
  logic unused_mdu_s;
  assign mdu_start_s  = 1'b0;
  assign mdu_done_s   = 1'b0;
  assign unused_mdu_s = bus.mdu_start ^ bus.mdu_done;
`endif

  hazard_detect u_hazard_detect (
    .mem_read (bus.id_ex_mem_read),
    .ex_rd    (bus.id_ex_rd),
    .rs1      (bus.id_rs1),
    .uses_rs1 (bus.id_uses_rs1),
    .rs2      (bus.id_rs2),
    .uses_rs2 (bus.id_uses_rs2),
    .load_use (load_use_s)
  );

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Watchdog counter: cleared on entry, counts cycles spent waiting in MDU_BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if (mdu_entry_s) begin
      wait_cnt_r <= '0;
    end else if (state_r == MDU_BUSY) begin
      wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Next-state and pipeline control decode.
  always_comb begin
    state_next_s    = state_r;
    mdu_entry_s     = 1'b0;
    pc_stall_s      = 1'b0;
    if_id_stall_s   = 1'b0;
    if_id_flush_s   = 1'b0;
    id_ex_flush_s   = 1'b0;
    ex_mem_bubble_s = 1'b0;
    mdu_timeout_s   = 1'b0;
    case (state_r)
      RUN: begin
        if (bus.ex_branch_taken) begin
          // The branch kills both the load-use stall and any MDU issue.
          if_id_flush_s = 1'b1;
          id_ex_flush_s = 1'b1;
        end else begin
          // An MDU op finishing in its issue cycle needs no wait at all.
          if (mdu_start_s && !mdu_done_s) begin
            mdu_entry_s     = 1'b1;
            state_next_s    = MDU_BUSY;
            pc_stall_s      = 1'b1;
            if_id_stall_s   = 1'b1;
            ex_mem_bubble_s = 1'b1;
          end else begin
            mdu_entry_s = 1'b0;
          end
          if (load_use_s) begin
            pc_stall_s    = 1'b1;
            if_id_stall_s = 1'b1;
            id_ex_flush_s = 1'b1;
          end else begin
            id_ex_flush_s = 1'b0;
          end
        end
      end
      MDU_BUSY: begin
        if (mdu_done_s) begin
          // Result is available this cycle: release the pipeline now.
          state_next_s = RUN;
        end else begin
          pc_stall_s      = 1'b1;
          if_id_stall_s   = 1'b1;
          ex_mem_bubble_s = 1'b1;
          if (wait_cnt_r == WAIT_LAST) begin
            mdu_timeout_s = 1'b1;
            state_next_s  = RUN;
          end else begin
            state_next_s = MDU_BUSY;
          end
        end
      end
      default: begin
        state_next_s = RUN;
      end
    endcase
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= '0;
    end else if (pc_stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.pc_stall      = pc_stall_s      & ~rst;
  assign bus.if_id_stall   = if_id_stall_s   & ~rst;
  assign bus.if_id_flush   = if_id_flush_s   & ~rst;
  assign bus.id_ex_flush   = id_ex_flush_s   & ~rst;
  assign bus.ex_mem_bubble = ex_mem_bubble_s & ~rst;
  assign bus.mdu_timeout   = mdu_timeout_s   & ~rst;
  assign bus.stall_cnt     = stall_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl.
// Two instances run in lock-step on identical inputs: dut_a with default
// parameters, dut_b with MDU_MAX_CYCLES=8 and CNT_W=4 for watchdog and
// saturation corners. Expected values come from a cycle-level model written
// from the behavioural rules, plus a small table of fixed vectors.
module tb_pipe_ctrl;
`ifdef PIPE_CTRL_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  typedef struct packed {
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic       br;
    logic       ms;
    logic       md;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [5:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(16)) bus_a ();
  pipe_ctrl_if #(.CNT_W(4))  bus_b ();

  pipe_ctrl #(.MDU_MAX_CYCLES(64), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  pipe_ctrl #(.MDU_MAX_CYCLES(8),  .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Reference model state: busy flag, 1-based count of busy cycles, stall count.
  int m_max[2]  = '{64, 8};
  int m_cmax[2] = '{65535, 15};
  bit m_busy[2];
  int m_bc[2];
  int m_cnt[2];

  function automatic in_t mk(input logic mr, input int rd, input int rs1, input logic u1,
                             input int rs2, input logic u2, input logic br,
                             input logic ms, input logic md);
    in_t v;
    v.mr = mr; v.rd = 5'(rd); v.rs1 = 5'(rs1); v.u1 = u1;
    v.rs2 = 5'(rs2); v.u2 = u2; v.br = br; v.ms = ms; v.md = md;
    return v;
  endfunction

  function automatic logic [5:0] outs(input int i);
    if (i == 0) return {bus_a.pc_stall, bus_a.if_id_stall, bus_a.if_id_flush,
                        bus_a.id_ex_flush, bus_a.ex_mem_bubble, bus_a.mdu_timeout};
    return {bus_b.pc_stall, bus_b.if_id_stall, bus_b.if_id_flush,
            bus_b.id_ex_flush, bus_b.ex_mem_bubble, bus_b.mdu_timeout};
  endfunction

  function automatic int cnt_of(input int i);
    return (i == 0) ? int'(bus_a.stall_cnt) : int'(bus_b.stall_cnt);
  endfunction

  task automatic drive(input in_t v);
    bus_a.id_ex_mem_read = v.mr; bus_b.id_ex_mem_read = v.mr;
    bus_a.id_ex_rd = v.rd;       bus_b.id_ex_rd = v.rd;
    bus_a.id_rs1 = v.rs1;        bus_b.id_rs1 = v.rs1;
    bus_a.id_uses_rs1 = v.u1;    bus_b.id_uses_rs1 = v.u1;
    bus_a.id_rs2 = v.rs2;        bus_b.id_rs2 = v.rs2;
    bus_a.id_uses_rs2 = v.u2;    bus_b.id_uses_rs2 = v.u2;
    bus_a.ex_branch_taken = v.br; bus_b.ex_branch_taken = v.br;
    bus_a.mdu_start = v.ms;      bus_b.mdu_start = v.ms;
    bus_a.mdu_done = v.md;       bus_b.mdu_done = v.md;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for this cycle (pre-edge stall count), then advance one edge.
  task automatic model(input int i, input in_t v, output logic [5:0] e, output int ecnt);
    bit lu, start, stall, bub, tmo, ifl, xfl;
    lu = v.mr && (v.rd != 5'd0) && ((v.u1 && v.rd == v.rs1) || (v.u2 && v.rd == v.rs2));
    start = 0; stall = 0; bub = 0; tmo = 0; ifl = 0; xfl = 0;
    if (!m_busy[i]) begin
      if (v.br) begin
        ifl = 1; xfl = 1;
      end else begin
        start = MDU_EN && v.ms && !v.md;
        stall = start || lu;
        bub   = start;
        xfl   = lu;
      end
    end else if (!v.md) begin
      stall = 1; bub = 1;
      tmo = (m_bc[i] == m_max[i]);
    end
    e = {stall, stall, ifl, xfl, bub, tmo};
    ecnt = m_cnt[i];
    if (stall && m_cnt[i] < m_cmax[i]) m_cnt[i]++;
    if (!m_busy[i]) begin
      if (start) begin m_busy[i] = 1; m_bc[i] = 1; end
    end else if (v.md || tmo) begin
      m_busy[i] = 0;
    end else begin
      m_bc[i]++;
    end
  endtask

  // One clock cycle: drive after the falling edge, check before the rising edge.
  task automatic cycle(input in_t v, input bit use_exp, input logic [5:0] texp, input string tname);
    logic [5:0] e;
    int ec;
    @(negedge clk);
    drive(v);
    #1;
    for (int i = 0; i < 2; i++) begin
      model(i, v, e, ec);
      check($sformatf("outs[%0d]", i), int'(outs(i)), int'(e));
      check($sformatf("stall_cnt[%0d]", i), cnt_of(i), ec);
    end
    if (use_exp) check(tname, int'(outs(0)), int'(texp));
  endtask

  task automatic idle(input in_t v);
    cycle(v, 1'b0, 6'd0, "");
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_outs[%0d]", i), int'(outs(i)), 0);
      check($sformatf("rst_cnt[%0d]", i), cnt_of(i), 0);
      m_busy[i] = 0; m_bc[i] = 0; m_cnt[i] = 0;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[10];
  in_t  nop, v;
  int   n_stall, t_idx;

  initial begin
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin m_busy[i] = 0; m_bc[i] = 0; m_cnt[i] = 0; end
    // Branch driven during reset must not leak through.
    drive(mk(1, 5, 5, 1, 0, 0, 1, 1, 0));
    #3;
    check("reset_outs_a", int'(outs(0)), 0);
    check("reset_outs_b", int'(outs(1)), 0);
    check("reset_cnt_a", cnt_of(0), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    tbl[0] = '{"lu_rs1",      mk(1, 5, 5, 1, 0, 0, 0, 0, 0), 6'b110100};
    tbl[1] = '{"lu_rd0",      mk(1, 0, 0, 1, 0, 0, 0, 0, 0), 6'b000000};
    tbl[2] = '{"lu_unused",   mk(1, 5, 5, 0, 0, 0, 0, 0, 0), 6'b000000};
    tbl[3] = '{"lu_rs2",      mk(1, 7, 0, 0, 7, 1, 0, 0, 0), 6'b110100};
    tbl[4] = '{"br_over_lu",  mk(1, 5, 5, 1, 0, 0, 1, 0, 0), 6'b001100};
    tbl[5] = '{"no_load",     mk(0, 5, 5, 1, 5, 1, 0, 0, 0), 6'b000000};
    tbl[6] = '{"done_in_run", mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 6'b000000};
    tbl[7] = '{"start_done",  mk(0, 0, 0, 0, 0, 0, 0, 1, 1), 6'b000000};
    tbl[8] = '{"br_over_mdu", mk(0, 0, 0, 0, 0, 0, 1, 1, 0), 6'b001100};
    tbl[9] = '{"lu_mismatch", mk(1, 5, 6, 1, 5, 0, 0, 0, 0), 6'b000000};
    for (int k = 0; k < 10; k++) cycle(tbl[k].in, 1'b1, tbl[k].exp, tbl[k].name);
    idle(nop);
    check("cnt_after_table", int'(bus_a.stall_cnt), 2);

    // MDU op completing 10 cycles after issue: 10 stalled cycles, then RUN.
    n_stall = 0;
    idle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    n_stall += int'(bus_a.pc_stall);
    for (int k = 1; k < 10; k++) begin
      idle(nop);
      n_stall += int'(bus_a.pc_stall);
    end
    idle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    check("mdu_done_cycle_stall", int'(bus_a.pc_stall), 0);
    check("mdu10_stall_cycles", n_stall, MDU_EN ? 10 : 0);
    idle(mk(1, 3, 3, 1, 0, 0, 0, 0, 0));
    check("run_after_mdu", int'(outs(0)), int'(6'b110100));

    // Watchdog on dut_b: pulse on the 8th busy cycle while dut_a keeps waiting.
    idle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    t_idx = 0;
    for (int k = 1; k <= 10; k++) begin
      idle(nop);
      if (bus_b.mdu_timeout) t_idx = k;
    end
    check("timeout_cycle", t_idx, MDU_EN ? 8 : 0);
    check("a_still_busy", int'(bus_a.ex_mem_bubble), int'(MDU_EN));
    idle(mk(1, 4, 4, 1, 0, 0, 0, 0, 0));
    check("b_run_after_timeout", int'(outs(1)), int'(6'b110100));
    idle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Saturation of the 4-bit counter after 20 stalls.
    do_reset();
    for (int k = 0; k < 20; k++) idle(mk(1, 9, 0, 0, 9, 1, 0, 0, 0));
    idle(nop);
    check("cnt4_saturated", int'(bus_b.stall_cnt), 15);
    check("cnt16_twenty", int'(bus_a.stall_cnt), 20);

    // Reset while waiting on the MDU: immediate clear, back in RUN, no timeout.
    idle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 3; k++) idle(nop);
    do_reset();
    idle(mk(1, 2, 2, 1, 0, 0, 0, 0, 0));
    check("run_after_rst", int'(outs(0)), int'(6'b110100));
    for (int k = 0; k < 10; k++) begin
      idle(nop);
      check("no_tmo_after_rst", int'(bus_b.mdu_timeout), 0);
    end

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      v.mr  = ($urandom_range(0, 1) == 0);
      v.rd  = 5'($urandom_range(0, 3));
      v.rs1 = 5'($urandom_range(0, 3));
      v.u1  = 1'($urandom_range(0, 1));
      v.rs2 = 5'($urandom_range(0, 3));
      v.u2  = 1'($urandom_range(0, 1));
      v.br  = ($urandom_range(0, 7) == 0);
      v.ms  = ($urandom_range(0, 9) == 0);
      v.md  = ($urandom_range(0, 11) == 0);
      idle(v);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
